// File: rtl/lane_traffic_if.sv
// Lane controller bundle: control/config from the game FSM,
// packed car positions and status back to the renderer.
interface lane_traffic_if #(
  parameter int NUM_CARS = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
);
  logic                      start;
  logic                      pause;
  logic                      frame_tick;
  logic                      direction;
  logic [3:0]                step;
  logic [3:0]                frame_div;
  logic [X_W-1:0]            start_x;
  logic [Y_W-1:0]            start_y;
  logic [NUM_CARS*X_W-1:0]   car_x_flat;
  logic [Y_W-1:0]            car_y;
  logic                      busy;
  logic                      running;
  logic                      step_pulse;

  modport master (
    output start, pause, frame_tick, direction,
    output step, frame_div, start_x, start_y,
    input  car_x_flat, car_y, busy, running, step_pulse
  );

  modport slave (
    input  start, pause, frame_tick, direction,
    input  step, frame_div, start_x, start_y,
    output car_x_flat, car_y, busy, running, step_pulse
  );
endinterface

// File: rtl/lane_traffic.sv
// Multi-car lane controller: sequential load of evenly spaced cars,
// then frame-divided wrapping motion with pause.
module lane_traffic #(
  parameter int NUM_CARS  = 4,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int H_DISPLAY = 640,
  parameter int SPACING   = 160
) (
  input  logic         clk,
  input  logic         reset,
  lane_traffic_if.slave lt
);
  localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

  typedef logic [X_W:0] xw_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;

  localparam xw_t HD = xw_t'(H_DISPLAY);
  localparam xw_t SP = xw_t'(SPACING);

  state_t         state, state_n;
  logic [X_W-1:0] car_x [NUM_CARS];
  logic [X_W-1:0] mv_x  [NUM_CARS];
  logic [X_W-1:0] lx;
  logic [X_W-1:0] ld_x;
  logic [Y_W-1:0] y_q;
  logic [IDX_W-1:0] idx;
  logic [3:0]     cnt;
  logic           sp_q;
  logic           last;
  logic           tick_go;
  logic           move;
  xw_t            ld_sum;

  function automatic logic [X_W-1:0] mv(
    input logic [X_W-1:0] x,
    input logic [3:0]     s,
    input logic           dir
  );
    xw_t xe, se, n;
    xe = {1'b0, x};
    se = xw_t'(s);
    if (!dir) begin
      n = xe + se;
      if (n >= HD) n = n - HD;
    end else if (xe >= se) begin
      n = xe - se;
    end else begin
      n = xe + HD - se;
    end
    return X_W'(n);
  endfunction

  assign last    = (idx == IDX_W'(NUM_CARS - 1));
  // start outranks a tick, and pause in RUN outranks it too
  assign tick_go = (state == RUN) && !lt.start
                && !lt.pause && lt.frame_tick;
  assign move    = tick_go && (cnt == lt.frame_div);

  always_comb begin
    ld_sum = {1'b0, lx} + SP * xw_t'(idx);
    ld_x   = (ld_sum >= HD) ? X_W'(ld_sum - HD)
                            : X_W'(ld_sum);
  end

  always_comb begin
    for (int i = 0; i < NUM_CARS; i++)
      mv_x[i] = mv(car_x[i], lt.step, lt.direction);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (lt.start) begin
      state_n = LOAD;
    end else begin
      case (state)
        LOAD:    if (last)       state_n = RUN;
        RUN:     if (lt.pause)   state_n = PAUSE;
        PAUSE:   if (!lt.pause)  state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CARS; i++)
        car_x[i] <= '0;
      lx   <= '0;
      y_q  <= '0;
      idx  <= '0;
      cnt  <= '0;
      sp_q <= 1'b0;
    end else begin
      sp_q <= move;
      if (lt.start) begin
        lx  <= lt.start_x;
        y_q <= lt.start_y;
        idx <= '0;
      end else if (state == LOAD) begin
        car_x[idx] <= ld_x;
        idx        <= last ? '0 : idx + IDX_W'(1);
        if (last) cnt <= '0;
      end else if (tick_go) begin
        if (move) begin
          cnt <= '0;
          for (int i = 0; i < NUM_CARS; i++)
            car_x[i] <= mv_x[i];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    lt.car_x_flat = '0;
    for (int i = 0; i < NUM_CARS; i++)
      lt.car_x_flat[i*X_W +: X_W] = car_x[i];
  end

  assign lt.car_y      = y_q;
  assign lt.busy       = (state == LOAD);
  assign lt.running    = (state == RUN) || (state == PAUSE);
  assign lt.step_pulse = sp_q;
endmodule

// File: tb/tb_lane_traffic.sv
// Bench for lane_traffic: directed plan items plus random traffic
// scored against a modular-arithmetic lane model.
module tb_lane_traffic;
  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int H  = 640;
  localparam int SP = 160;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lane_traffic_if #(.NUM_CARS(N), .X_W(XW), .Y_W(YW)) lt ();

  lane_traffic #(
    .NUM_CARS(N), .X_W(XW), .Y_W(YW),
    .H_DISPLAY(H), .SPACING(SP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lt(lt)
  );

  typedef struct {
    logic [N*XW-1:0] x;
    logic [YW-1:0]   y;
    logic            b;
    logic            r;
    logic            s;
  } snap_t;

  snap_t q[$];
  snap_t e;
  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 loading, 2 run, 3 paused
  int m_mode, m_k, m_base, m_y, m_cnt;
  int m_pos[N];
  bit m_sp;

  function automatic logic [N*XW-1:0] pk4(int a, int b, int c, int d);
    return {XW'(d), XW'(c), XW'(b), XW'(a)};
  endfunction

  function automatic logic [N*XW-1:0] packm();
    logic [N*XW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*XW +: XW] = XW'(m_pos[i]);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_base = 0; m_y = 0; m_cnt = 0; m_sp = 0;
    for (int i = 0; i < N; i++) m_pos[i] = 0;
  endtask

  task automatic cyc(bit st, bit pa, bit tk, bit dr,
                     int stp, int fd, int sx, int sy);
    snap_t s;
    @(negedge clk);
    lt.start      = st;
    lt.pause      = pa;
    lt.frame_tick = tk;
    lt.direction  = dr;
    lt.step       = 4'(stp);
    lt.frame_div  = 4'(fd);
    lt.start_x    = XW'(sx);
    lt.start_y    = YW'(sy);
    m_sp = 0;
    if (st) begin
      m_mode = 1; m_k = 0; m_base = sx; m_y = sy;
    end else begin
      case (m_mode)
        1: begin
          m_pos[m_k] = (m_base + m_k * SP) % H;
          m_k++;
          if (m_k == N) begin m_mode = 2; m_cnt = 0; end
        end
        2: begin
          if (pa) m_mode = 3;
          else if (tk) begin
            if (m_cnt == fd) begin
              m_cnt = 0;
              m_sp = 1;
              for (int i = 0; i < N; i++)
                m_pos[i] = ((m_pos[i] + (dr ? -stp : stp)) % H + H) % H;
            end else begin
              m_cnt = (m_cnt + 1) % 16;
            end
          end
        end
        3: if (!pa) m_mode = 2;
        default: ;
      endcase
    end
    s.x = packm();
    s.y = YW'(m_y);
    s.b = (m_mode == 1);
    s.r = (m_mode == 2) || (m_mode == 3);
    s.s = m_sp;
    q.push_back(s);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(bit dr, int stp, int fd);
    cyc(0, 0, 1, dr, stp, fd, 0, 0);
  endtask

  task automatic load(int sx, int sy);
    cyc(1, 0, 0, 0, 0, 0, sx, sy);
    idle(N);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_x", 64'(lt.car_x_flat), 64'(e.x));
        chk("sb_ctl",
            64'({lt.car_y, lt.busy, lt.running, lt.step_pulse}),
            64'({e.y, e.b, e.r, e.s}));
      end
    end
  end

  initial begin
    int nb;
    bit pa;
    int fd;
    lt.start = 0; lt.pause = 0; lt.frame_tick = 0; lt.direction = 0;
    lt.step = 0; lt.frame_div = 0; lt.start_x = 0; lt.start_y = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", 64'(lt.car_x_flat), 64'(0));
    chk("rst_ctl",
        64'({lt.car_y, lt.busy, lt.running, lt.step_pulse}), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // plan 1: load timing and spacing with wrap
    cyc(1, 0, 0, 0, 0, 0, 600, 200);
    nb = 0;
    repeat (6) begin
      settle();
      nb += int'(lt.busy);
      idle(1);
    end
    chk("busy_cycles", 64'(nb), 64'(4));
    settle();
    chk("t1_x", 64'(lt.car_x_flat), 64'(pk4(600, 120, 280, 440)));
    chk("t1_ctl", 64'({lt.car_y, lt.running, lt.step_pulse}),
        64'({10'd200, 1'b1, 1'b0}));

    // plan 2: right wrap
    load(638, 0);
    tick(0, 3, 0);
    settle();
    chk("t2_x", 64'(lt.car_x_flat), 64'(pk4(1, 161, 321, 481)));
    chk("t2_sp", 64'(lt.step_pulse), 64'(1));
    idle(1);
    settle();
    chk("t2_sp_drop", 64'(lt.step_pulse), 64'(0));

    // plan 3: left wrap
    load(2, 0);
    tick(1, 5, 0);
    settle();
    chk("t3_x", 64'(lt.car_x_flat), 64'(pk4(637, 157, 317, 477)));

    // plan 4: divider and pause
    load(10, 0);
    tick(0, 1, 2);
    tick(0, 1, 2);
    settle();
    chk("t4_div_hold", 64'(lt.car_x_flat), 64'(pk4(10, 170, 330, 490)));
    tick(0, 1, 2);
    settle();
    chk("t4_div_move", 64'(lt.car_x_flat), 64'(pk4(11, 171, 331, 491)));
    tick(0, 1, 2);
    cyc(0, 1, 0, 0, 1, 2, 0, 0);
    repeat (5) cyc(0, 1, 1, 0, 1, 2, 0, 0);
    settle();
    chk("t4_pause_x", 64'(lt.car_x_flat), 64'(pk4(11, 171, 331, 491)));
    chk("t4_pause_run", 64'(lt.running), 64'(1));
    cyc(0, 0, 0, 0, 1, 2, 0, 0);
    tick(0, 1, 2);
    settle();
    chk("t4_rel_1", 64'(lt.car_x_flat), 64'(pk4(11, 171, 331, 491)));
    tick(0, 1, 2);
    settle();
    chk("t4_rel_2", 64'(lt.car_x_flat), 64'(pk4(12, 172, 332, 492)));

    // plan 5: start beats tick; restart during load
    cyc(1, 0, 1, 0, 1, 0, 0, 0);
    settle();
    chk("t5_no_move", 64'({lt.car_x_flat, lt.step_pulse}),
        64'({pk4(12, 172, 332, 492), 1'b0}));
    idle(N);
    settle();
    chk("t5_x", 64'(lt.car_x_flat), 64'(pk4(0, 160, 320, 480)));
    cyc(1, 0, 0, 0, 0, 0, 100, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 200, 0);
    idle(N);
    settle();
    chk("t5_reload", 64'(lt.car_x_flat), 64'(pk4(200, 360, 520, 40)));

    // plan 6: asynchronous reset mid-run
    tick(0, 3, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_x", 64'(lt.car_x_flat), 64'(0));
    chk("t6_rst_ctl",
        64'({lt.car_y, lt.busy, lt.running, lt.step_pulse}), 64'(0));
    model_reset();
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick(0, 3, 0);
    settle();
    chk("t6_idle_x", 64'({lt.car_x_flat, lt.running}), 64'(0));

    // random traffic
    pa = 0;
    fd = 0;
    for (int i = 0; i < 3000; i++) begin
      bit st;
      st = (i == 0) || ($urandom_range(0, 49) == 0);
      if (st) fd = $urandom_range(0, 3);
      if ($urandom_range(0, 14) == 0) pa = ~pa;
      cyc(st, pa, ($urandom_range(0, 2) == 0), 1'($urandom),
          $urandom_range(0, 15), fd,
          $urandom_range(0, H - 1), $urandom_range(0, 1023));
    end
    idle(2);
    @(posedge clk);
    #3;
    chk("sb_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lane_traffic.md
Name: lane_traffic

Overview:
Parametrised multi-car lane controller for the road section of the game. It drives NUM_CARS cars sharing one lane (one Y, one direction), evenly spaced, with modular horizontal wrap. Cars advance on video frame ticks with a programmable frame divider and step size. Compared with the single-car mover, it adds a sequential load, pause, and frame-synchronous motion; the renderer reads the packed X bus.

Parameters:
NUM_CARS, 4, cars in the lane (1..8)
X_W, 10, width of each X coordinate
Y_W, 10, width of Y coordinate
H_DISPLAY, 640, horizontal wrap modulus; legal X is 0..H_DISPLAY-1
SPACING, 160, X distance between consecutive cars; NUM_CARS*SPACING <= H_DISPLAY

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: (re)load lane from start_x/start_y, then run
pause  in  1  level; freezes motion and the frame counter while high in RUN
frame_tick  in  1  one-cycle pulse per video frame (from VGA sync)
direction  in  1  0 = left to right (X increasing), 1 = right to left
step  in  4  pixels moved per move event (0 = no motion)
frame_div  in  4  move every frame_div+1 frame ticks
start_x  in  X_W  X of car 0; must be < H_DISPLAY
start_y  in  Y_W  lane Y
car_x_flat  out  NUM_CARS*X_W  car i X at bits [i*X_W +: X_W]
car_y  out  Y_W  lane Y
busy  out  1  high during LOAD
running  out  1  high in RUN or PAUSE
step_pulse  out  1  one-cycle pulse in the cycle new X values first appear

Behaviour:
- Reset (reset=0, async): state IDLE; all car_x=0, car_y=0, busy=0, running=0, step_pulse=0, frame count=0, load index=0. A reset mid-LOAD or mid-RUN aborts immediately.
- States: IDLE, LOAD, RUN, PAUSE.
- IDLE: outputs hold. start -> LOAD.
- Entering LOAD: latch start_x and start_y; car_y <= start_y; index=0; busy=1.
- LOAD: one car per cycle. car[idx] <= latched_x + idx*SPACING, minus H_DISPLAY if the sum is >= H_DISPLAY (one conditional subtract suffices). The load takes NUM_CARS cycles.
- After the last car is written: -> RUN; busy=0; running=1; frame count=0.
- start in any state (including LOAD) restarts LOAD with freshly latched values. frame_tick is ignored in LOAD and IDLE.
- RUN, on frame_tick:
  - If count==frame_div: count<=0 and move all cars in the same cycle. New X values and step_pulse are visible at the next edge, i.e. 1 cycle of latency.
  - Else: count<=count+1.
- Move rule (direction, step and frame_div are sampled in the tick cycle):
  - dir=0: n=x+step; if n>=H_DISPLAY then n-H_DISPLAY.
  - dir=1: if x>=step then x-step, else x+H_DISPLAY-step.
  - Intermediates are X_W+1 bits.
  - step=0 still produces step_pulse with positions unchanged.
- PAUSE: entered from RUN when pause=1; returns to RUN when pause=0. The frame count and positions are held; frame_tick is ignored; running stays 1.
- Simultaneous events:
  - start and frame_tick together: start wins, no move.
  - pause and frame_tick together in RUN: pause wins, no move.
- step_pulse is never high outside the cycle following a move.
- Changing direction mid-run takes effect at the next move event; there is no glitch.

Test Plan:
1. Defaults. Pulse start with start_x=600, start_y=200 -> busy high exactly 4 cycles. Then car_x = {600,120,280,440}, car_y=200, running=1, step_pulse=0.
2. start_x=638, dir=0, step=3, frame_div=0, one frame_tick -> next cycle car_x = {1,161,321,481}, step_pulse high 1 cycle.
3. start_x=2, dir=1, step=5, frame_div=0, one frame_tick -> car_x = {637,157,317,477}.
4. frame_div=2, step=1 -> first two ticks give no change; third tick moves all cars +1.
   - Same setup, but pause=1 across 5 ticks after tick 1, then release -> positions unchanged during the pause; the move occurs on the 2nd tick after release.
5. In RUN, assert start and frame_tick together with start_x=0 -> no move, busy 4 cycles, car_x = {0,160,320,480}.
   - Second start pulsed during LOAD -> reload restarts from index 0.
6. Mid-RUN, assert reset=0 asynchronously between clock edges -> all outputs 0 immediately. After release, stays IDLE; frame_ticks cause no motion until start.
